std_sync_get: RTL
=================

Name: std_sync_get

Overview:
- Reader-side sequencer for the blocking M-structure register (`std_sync_reg`).
- Gives a Calyx group a simple go/done "get" operation.
- Drives the register's `read_en` one attempt at a time and samples its `blocked`/`out` response.
- On a blocked attempt it backs off and retries. It delivers the value, or flags a timeout after a bounded number of failed attempts.

Parameters:
- WIDTH, 32: data width; must match the attached register.
- BACKOFF, 2: idle cycles between a failed attempt and the next request (0 allowed).
- MAX_RETRIES, 0: failed attempts before giving up; 0 means retry forever.
- CNT_WIDTH, 16: width of the `retries` counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous reset, active-low: reset==0 at a posedge resets the block.
- go  input  1  start a get; sampled only in IDLE.
- sync_out  input  WIDTH  register `out`; valid in the cycle after a successful read request.
- sync_blocked  input  1  register `blocked`; must be the read-side indication only.
- read_en  output  1  read request to the register.
- out  output  WIDTH  last successfully read value.
- done  output  1  one-cycle pulse: get completed, `out` valid.
- timeout  output  1  one-cycle pulse: get abandoned after MAX_RETRIES failures.
- retries  output  CNT_WIDTH  failed attempts in the current or most recent get.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; out=0, done=0, timeout=0, retries=0.
  - read_en is gated combinationally low while reset==0.
  - Reset mid-operation abandons the get with no done or timeout pulse.
- States: IDLE, REQ, WAIT, BACK, FIN.
- IDLE: go==1 -> REQ, and retries cleared to 0. go==0 -> stay.
- REQ: read_en=1 for exactly this one cycle; always -> WAIT. read_en is 0 in every other state.
- WAIT: read_en=0; sample sync_blocked and sync_out.
  - sync_blocked==0: out<=sync_out, done<=1, -> FIN.
  - sync_blocked==1: retries<=retries+1, saturating at 2^CNT_WIDTH-1.
    - If MAX_RETRIES!=0 and the incremented count >= MAX_RETRIES: timeout<=1, -> FIN.
    - Else if BACKOFF==0: -> REQ.
    - Else -> BACK with the backoff counter loaded to BACKOFF-1.
- BACK: count down; at 0 -> REQ. Exactly BACKOFF idle cycles between WAIT and the next REQ.
- FIN: done or timeout is high this cycle only (registered); always -> IDLE. go is ignored here, so the parent dropping go after seeing done cannot cause a double read.
- Latency:
  - go high in cycle 0 (IDLE): REQ in cycle 1, WAIT in cycle 2, done and valid out in cycle 3.
  - Each failed attempt adds 2+BACKOFF cycles.
- Output holding:
  - out holds its value until the next successful read; it is unchanged on timeout.
  - retries holds after FIN until the next get starts.
- go:
  - go toggling in REQ/WAIT/BACK/FIN has no effect.
  - go high continuously starts a new get from each IDLE visit.
- done and timeout are never high in the same cycle.
- sync_out is sampled only in WAIT with sync_blocked==0; any other value (including X) is ignored.

Test Plan:
- Register full with 0xDEADBEEF, go pulse at cycle 0 -> read_en high in cycle 1 only; done in cycle 3; out=0xDEADBEEF; retries=0.
- Register empty, BACKOFF=2; a writer stores 0x12 after 3 failed attempts -> read_en pulses spaced 4 cycles apart; done with out=0x12, retries=3.
- MAX_RETRIES=2, register never written -> two read_en pulses, timeout pulse one cycle, done never high, out keeps its previous value, retries=2.
- BACKOFF=0, blocked twice then success -> read_en high every other cycle; done 7 cycles after go.
- reset driven 0 while in BACK -> next cycle state IDLE, all outputs 0, read_en 0, no done/timeout; a later go completes normally.
- go held high through FIN with the register refilled -> second get starts from IDLE the cycle after FIN; exactly one read_en per attempt, no read_en in FIN.

Source files
------------

// File: rtl/std_sync_get_if.sv
// Handshake bundle between a get sequencer, its parent group and the attached
// blocking register: go/done/timeout toward the parent, read_en/blocked/out toward the register.
interface std_sync_get_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
);
    logic                 go;
    logic [WIDTH-1:0]     sync_out;
    logic                 sync_blocked;
    logic                 read_en;
    logic [WIDTH-1:0]     out;
    logic                 done;
    logic                 timeout;
    logic [CNT_WIDTH-1:0] retries;

    // master: the parent group together with the register it reads from
    modport master (
        output go, sync_out, sync_blocked,
        input  read_en, out, done, timeout, retries
    );

    // slave: the get sequencer itself
    modport slave (
        input  go, sync_out, sync_blocked,
        output read_en, out, done, timeout, retries
    );
endinterface

// File: rtl/std_sync_get.sv
// Reader-side sequencer for a blocking M-structure register: one read attempt
// at a time, back off and retry while blocked, finish with done or timeout.
module std_sync_get #(
    parameter int WIDTH       = 32,
    parameter int BACKOFF     = 2,
    parameter int MAX_RETRIES = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic           clk,
    input  logic           reset,
    std_sync_get_if.slave  bus
);
    localparam int BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
    localparam logic [BW-1:0]        BLOAD = (BACKOFF > 0) ? BW'(BACKOFF - 1) : '0;
    localparam logic [CNT_WIDTH-1:0] MAX_R = CNT_WIDTH'(MAX_RETRIES);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, BACK, FIN} state_t;

    state_t               state, state_n;
    logic [WIDTH-1:0]     out_q, out_n;
    logic                 done_q, done_n;
    logic                 timeout_q, timeout_n;
    logic [CNT_WIDTH-1:0] retries_q, retries_n, retries_inc;
    logic [BW-1:0]        bcnt, bcnt_n;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            out_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            retries_q <= '0;
            bcnt      <= '0;
        end else begin
            state     <= state_n;
            out_q     <= out_n;
            done_q    <= done_n;
            timeout_q <= timeout_n;
            retries_q <= retries_n;
            bcnt      <= bcnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        out_n       = out_q;
        done_n      = 1'b0;
        timeout_n   = 1'b0;
        retries_n   = retries_q;
        bcnt_n      = bcnt;
        retries_inc = sat_inc(retries_q);
        unique case (state)
            IDLE: begin
                if (bus.go) begin
                    state_n   = REQ;
                    retries_n = '0;
                end
            end
            REQ:  state_n = WAIT;
            WAIT: begin
                // The register answers in the cycle after the request.
                if (!bus.sync_blocked) begin
                    out_n   = bus.sync_out;
                    done_n  = 1'b1;
                    state_n = FIN;
                end else begin
                    retries_n = retries_inc;
                    if ((MAX_RETRIES != 0) && (retries_inc >= MAX_R)) begin
                        timeout_n = 1'b1;
                        state_n   = FIN;
                    end else if (BACKOFF == 0) begin
                        state_n = REQ;
                    end else begin
                        state_n = BACK;
                        bcnt_n  = BLOAD;
                    end
                end
            end
            BACK: begin
                if (bcnt == '0) state_n = REQ;
                else            bcnt_n  = bcnt - BW'(1);
            end
            // go is ignored here so a parent still holding go cannot double-read.
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign bus.read_en = reset && (state == REQ);
    assign bus.out     = out_q;
    assign bus.done    = done_q;
    assign bus.timeout = timeout_q;
    assign bus.retries = retries_q;
endmodule
